// File: rtl/timer_pkg.sv
// Shared definitions for the memory-mapped countdown timer: FSM states,
// register offsets, CTRL bit positions and mode codes.
package timer_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      CNT  = 2'd2,
      INT  = 2'd3
   } timer_state_e;

   // Word offsets decoded from addr[3:2]
   localparam logic [1:0] TMR_CTRL   = 2'd0;
   localparam logic [1:0] TMR_PRESET = 2'd1;
   localparam logic [1:0] TMR_COUNT  = 2'd2;
   localparam logic [1:0] TMR_RSVD   = 2'd3;

   localparam int EN_BIT   = 0;
   localparam int MODE_LSB = 1;
   localparam int MODE_MSB = 2;
   localparam int IM_BIT   = 3;
   localparam int CTRL_W   = 4;

   localparam logic [1:0] MODE_ONESHOT = 2'b00;
   localparam logic [1:0] MODE_RELOAD  = 2'b01;

   function automatic logic [31:0] ctrl_to_word(input logic [CTRL_W-1:0] c);
      return {{(32-CTRL_W){1'b0}}, c};
   endfunction

endpackage

// File: rtl/timer_dev_if.sv
// Data-memory bus between the M-stage bridge and the timer device,
// including the timer's interrupt request back to CP0.
interface timer_dev_if;
   logic [31:0] addr;
   logic        we;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        irq;

   modport master (
      output addr,
      output we,
      output wdata,
      input  rdata,
      input  irq
   );

   modport slave (
      input  addr,
      input  we,
      input  wdata,
      output rdata,
      output irq
   );
endinterface

// File: rtl/timer_dev_fsm.sv
// Countdown FSM for timer_dev: owns state, COUNT and irq_flag.
// Auto-reload (mode 01) exists only when TIMER_AUTO_RELOAD_EN is defined.
module timer_fsm
   import timer_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        en_i,
   input  logic [1:0]  mode_i,
   input  logic [31:0] preset_i,
   input  logic        ctrl_wr_i,
   output logic        en_clr_o,
   output logic [31:0] count_o,
   output logic        irq_flag_o
);

   timer_state_e state_q, state_d;
   logic [31:0]  count_q, count_d;
   logic         irq_flag_q, irq_flag_d;
   logic         reload;

`ifdef TIMER_AUTO_RELOAD_EN
   assign reload = (mode_i == MODE_RELOAD);
`else
   // Mode is still stored by the register block but never changes behaviour here
   logic mode_unused;
   assign mode_unused = ^mode_i;
   assign reload      = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         count_q    <= 32'd0;
         irq_flag_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         irq_flag_q <= irq_flag_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      irq_flag_d = irq_flag_q;
      en_clr_o   = 1'b0;

      // An expiry on the same edge as a CTRL write still raises the flag
      if (ctrl_wr_i) begin
         irq_flag_d = 1'b0;
      end

      unique case (state_q)
         IDLE: begin
            if (en_i) begin
               state_d = LOAD;
            end
         end
         LOAD: begin
            if (!en_i) begin
               state_d = IDLE;
            end else begin
               count_d = preset_i;
               state_d = CNT;
            end
         end
         CNT: begin
            if (!en_i) begin
               state_d = IDLE;
            end else if (count_q > 32'd1) begin
               count_d = count_q - 32'd1;
            end else begin
               count_d    = 32'd0;
               irq_flag_d = 1'b1;
               state_d    = INT;
            end
         end
         INT: begin
            if (reload) begin
               // Reload flag is a single-cycle pulse tied to the INT state
               irq_flag_d = 1'b0;
               state_d    = en_i ? LOAD : IDLE;
            end else begin
               en_clr_o = en_i;
               state_d  = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign count_o    = count_q;
   assign irq_flag_o = irq_flag_q;

endmodule

// File: rtl/timer_dev.sv
// Memory-mapped countdown timer: CTRL/PRESET registers, COUNT read-back and irq.
// Optional auto-reload mode is enabled by defining TIMER_AUTO_RELOAD_EN.
module timer_dev
   import timer_pkg::*;
#(
   parameter logic [1:0] BASE_SEL = 2'b00
) (
   input  logic        clk,
   input  logic        reset,
   timer_dev_if.slave  bus
);

   localparam logic [1:0] BANK_SEL_UNUSED = BASE_SEL;

   logic [1:0]        sel;
   logic              addr_unused;
   logic [CTRL_W-1:0] ctrl_q, ctrl_d;
   logic [31:0]       preset_q, preset_d;
   logic              ctrl_wr, preset_wr;
   logic              en_clr;
   logic [31:0]       count;
   logic              irq_flag;

   assign sel         = bus.addr[3:2];
   assign addr_unused = ^{bus.addr[31:4], bus.addr[1:0]};
   assign ctrl_wr     = bus.we && (sel == TMR_CTRL);
   assign preset_wr   = bus.we && (sel == TMR_PRESET);

   always_comb begin
      ctrl_d   = ctrl_q;
      preset_d = preset_q;
      // A CPU write to CTRL takes priority over the FSM's one-shot enable clear
      if (ctrl_wr) begin
         ctrl_d = bus.wdata[CTRL_W-1:0];
      end else if (en_clr) begin
         ctrl_d[EN_BIT] = 1'b0;
      end
      if (preset_wr) begin
         preset_d = bus.wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ctrl_q   <= '0;
         preset_q <= 32'd0;
      end else begin
         ctrl_q   <= ctrl_d;
         preset_q <= preset_d;
      end
   end

   timer_fsm u_fsm (
      .clk        (clk),
      .reset      (reset),
      .en_i       (ctrl_q[EN_BIT]),
      .mode_i     (ctrl_q[MODE_MSB:MODE_LSB]),
      .preset_i   (preset_q),
      .ctrl_wr_i  (ctrl_wr),
      .en_clr_o   (en_clr),
      .count_o    (count),
      .irq_flag_o (irq_flag)
   );

   always_comb begin
      bus.rdata = 32'd0;
      unique case (sel)
         TMR_CTRL:   bus.rdata = ctrl_to_word(ctrl_q);
         TMR_PRESET: bus.rdata = preset_q;
         TMR_COUNT:  bus.rdata = count;
         TMR_RSVD:   bus.rdata = 32'd0;
         default:    bus.rdata = 32'd0;
      endcase
   end

   assign bus.irq = ctrl_q[IM_BIT] & irq_flag;

endmodule

// File: tb/tb_timer_dev.sv
// Directed scoreboard bench for timer_dev: register map, one-shot and
// auto-reload expiry timing, freeze/re-enable, read-only COUNT and reset.
module tb_timer_dev;

   logic clk = 1'b0;
   logic reset;

   timer_dev_if bus();

   timer_dev #(.BASE_SEL(2'b00)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #10 clk = ~clk;

   typedef struct {
      string       tag;
      logic [31:0] exp;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;

   task automatic push(input string tag, input logic [31:0] e);
      exp_t x;
      x.tag = tag;
      x.exp = e;
      sb.push_back(x);
   endtask

   task automatic pop_check(input logic [31:0] obs);
      exp_t x;
      checks++;
      if (sb.size() == 0) begin
         errors++;
         $display("FAIL scoreboard_empty: observed 0x%08h required an expected entry", obs);
      end else begin
         x = sb.pop_front();
         assert (obs === x.exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", x.tag, obs, x.exp);
         end
      end
   endtask

   // Called just after a falling edge; the write lands on the next rising edge
   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      bus.addr  = a;
      bus.we    = 1'b1;
      bus.wdata = d;
      @(negedge clk);
      bus.we    = 1'b0;
   endtask

   task automatic chk_rd(input string tag, input logic [31:0] a, input logic [31:0] e);
      logic [31:0] v;
      push(tag, e);
      bus.addr = a;
      bus.we   = 1'b0;
      #1;
      v = bus.rdata;
      pop_check(v);
   endtask

   task automatic chk_irq(input string tag, input logic e);
      push(tag, {31'd0, e});
      #1;
      pop_check({31'd0, bus.irq});
   endtask

   task automatic wait_irq(output int n);
      n = 0;
      while (bus.irq !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic cycles(input int k);
      repeat (k) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      bus.addr  = 32'd0;
      bus.we    = 1'b0;
      bus.wdata = 32'd0;
      reset     = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      chk_rd("rst_ctrl",   32'h0, 32'h0);
      chk_rd("rst_preset", 32'h4, 32'h0);
      chk_rd("rst_count",  32'h8, 32'h0);
      chk_rd("rst_rsvd",   32'hC, 32'h0);
      chk_irq("rst_irq", 1'b0);

      // One-shot, PRESET = 5: irq after edge 0+2+5
      wr(32'h4, 32'd5);
      chk_rd("preset_rb", 32'h4, 32'd5);
      wr(32'h0, 32'h9);
      push("os_latency", 32'd7);
      wait_irq(n);
      pop_check(n);
      cycles(1);
      chk_rd("os_ctrl_en_cleared", 32'h0, 32'h8);
      chk_rd("os_count_zero", 32'h8, 32'h0);
      cycles(2);
      chk_irq("os_irq_held", 1'b1);
      wr(32'h0, 32'h8);
      chk_irq("os_irq_drop", 1'b0);

      // Mode 01, PRESET = 3
      wr(32'h4, 32'd3);
      wr(32'h0, 32'hB);
      push("ar_first", 32'd5);
      wait_irq(n);
      pop_check(n);
`ifdef TIMER_AUTO_RELOAD_EN
      for (int p = 0; p < 2; p++) begin
         cycles(1);
         chk_irq("ar_pulse_width", 1'b0);
         push("ar_period", 32'd5);
         wait_irq(n);
         pop_check(n + 1);
      end
`else
      cycles(3);
      chk_irq("ar_disabled_irq_held", 1'b1);
      chk_rd("ar_disabled_ctrl", 32'h0, 32'hA);
`endif
      wr(32'h0, 32'h8);
      cycles(2);
      chk_irq("ar_off", 1'b0);

      // Freeze mid-count, then re-enable
      wr(32'h4, 32'd100);
      wr(32'h0, 32'h9);
      cycles(9);
      wr(32'h0, 32'h8);
      chk_rd("freeze_count", 32'h8, 32'd92);
      cycles(3);
      chk_rd("freeze_hold", 32'h8, 32'd92);
      wr(32'h0, 32'h9);
      cycles(1);
      chk_rd("reload_pending", 32'h8, 32'd92);
      cycles(1);
      chk_rd("reload_count", 32'h8, 32'd100);
      wr(32'h0, 32'h8);

      // COUNT and the reserved slot ignore writes; PRESET = 0 expires at k+3
      wr(32'h4, 32'd0);
      wr(32'h8, 32'hFFFF);
      chk_rd("count_read_only", 32'h8, 32'd99);
      wr(32'hC, 32'h1234);
      chk_rd("rsvd_read_zero", 32'hC, 32'h0);
      wr(32'h0, 32'h9);
      push("p0_latency", 32'd3);
      wait_irq(n);
      pop_check(n);
      chk_rd("p0_count", 32'h8, 32'h0);

      // Reset during CNT beats a simultaneous CTRL write
      wr(32'h4, 32'd100);
      wr(32'h0, 32'h9);
      cycles(2);
      chk_rd("pre_reset_count", 32'h8, 32'd100);
      reset     = 1'b1;
      bus.addr  = 32'h0;
      bus.we    = 1'b1;
      bus.wdata = 32'hF;
      @(negedge clk);
      reset  = 1'b0;
      bus.we = 1'b0;
      chk_rd("mid_rst_ctrl",   32'h0, 32'h0);
      chk_rd("mid_rst_preset", 32'h4, 32'h0);
      chk_rd("mid_rst_count",  32'h8, 32'h0);
      chk_rd("mid_rst_rsvd",   32'hC, 32'h0);
      chk_irq("mid_rst_irq", 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
